// File: rtl/fifo_mem.sv
// Storage array for fifo_top: synchronous write port, asynchronous read port.
// Contents are deliberately not reset.
module fifo_mem #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             wclk,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] r_mem [DEPTH];

  // Write the addressed word on an effective write
  always_ff @(posedge wclk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  // Read port is purely combinational so the head word falls through
  always_comb begin
    rdata = r_mem[raddr];
  end

endmodule

// File: rtl/fifo_top.sv
// Single-clock first-word-fall-through FIFO with registered full/empty flags.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module fifo_top #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty
);

  logic [ASIZE:0] r_wptr;
  logic [ASIZE:0] r_rptr;
  logic           r_wfull;
  logic           r_rempty;

  logic           w_we;
  logic           w_re;
  logic [ASIZE:0] w_wptr_next;
  logic [ASIZE:0] w_rptr_next;
  logic           w_wfull_next;
  logic           w_rempty_next;

  // Qualify strobes with the registered flags and compute next pointers/flags
  always_comb begin
    w_we          = winc & ~r_wfull;
    w_re          = rinc & ~r_rempty;
    w_wptr_next   = r_wptr + {{ASIZE{1'b0}}, w_we};
    w_rptr_next   = r_rptr + {{ASIZE{1'b0}}, w_re};
    w_rempty_next = (w_rptr_next == w_wptr_next);
    w_wfull_next  = (w_rptr_next[ASIZE] != w_wptr_next[ASIZE]) &&
                    (w_rptr_next[ASIZE-1:0] == w_wptr_next[ASIZE-1:0]);
  end

  // Pointer and flag registers; async reset empties the FIFO immediately
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_wfull  <= 1'b0;
      r_rempty <= 1'b1;
    end else begin
      r_wptr   <= w_wptr_next;
      r_rptr   <= w_rptr_next;
      r_wfull  <= w_wfull_next;
      r_rempty <= w_rempty_next;
    end
  end

  // Drive flag outputs from their registers
  always_comb begin
    wfull  = r_wfull;
    rempty = r_rempty;
  end

  fifo_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_mem (
    .wclk  (wclk),
    .we    (w_we),
    .waddr (r_wptr[ASIZE-1:0]),
    .wdata (wdata),
    .raddr (r_rptr[ASIZE-1:0]),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_fifo_top.sv
// Randomised and directed bench for fifo_top against a queue-based model.
module tb_fifo_top;

  localparam int DSIZE = 6;
  localparam int ASIZE = 4;
  localparam int DEPTH = 1 << ASIZE;

  logic             wclk;
  logic             wrst_n;
  logic             winc;
  logic [DSIZE-1:0] wdata;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             wfull;
  logic             rempty;

  fifo_top #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .winc   (winc),
    .wdata  (wdata),
    .rinc   (rinc),
    .rdata  (rdata),
    .wfull  (wfull),
    .rempty (rempty)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  // Reference model: the ordered list of stored words
  logic [DSIZE-1:0] model_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Compare DUT outputs with the model (called away from the clock edge)
  task automatic check_state(input string tag);
    check({tag, ".rempty"}, {31'd0, rempty}, {31'd0, model_q.size() == 0});
    check({tag, ".wfull"},  {31'd0, wfull},  {31'd0, model_q.size() == DEPTH});
    if (model_q.size() != 0)
      check({tag, ".rdata"}, {26'd0, rdata}, {26'd0, model_q[0]});
  endtask

  // One clock cycle: check at the falling edge, drive, then apply FIFO rules to the model
  task automatic step(input string tag, input logic w, input logic [DSIZE-1:0] d, input logic r);
    bit do_w, do_r;
    @(negedge wclk);
    check_state(tag);
    winc  = w;
    wdata = d;
    rinc  = r;
    do_w  = w && (model_q.size() < DEPTH);
    do_r  = r && (model_q.size() > 0);
    @(posedge wclk);
    if (do_r) void'(model_q.pop_front());
    if (do_w) model_q.push_back(d);
  endtask

  initial begin
    logic [DSIZE-1:0] v;
    wrst_n = 1'b0;
    winc   = 1'b0;
    rinc   = 1'b0;
    wdata  = '0;
    #20;
    check("reset.rempty", {31'd0, rempty}, 32'd1);
    check("reset.wfull",  {31'd0, wfull},  32'd0);
    @(negedge wclk);
    wrst_n = 1'b1;

    // Single word
    step("single.wr", 1'b1, 6'h24, 1'b0);
    step("single.vis", 1'b0, '0, 1'b0);
    check("single.data", {26'd0, rdata}, 32'h24);
    step("single.rd", 1'b0, '0, 1'b1);
    step("single.end", 1'b0, '0, 1'b0);

    // Fill, overflow attempt, drain
    for (int i = 0; i < DEPTH; i++) step("fill.wr", 1'b1, DSIZE'(i), 1'b0);
    step("fill.ovf", 1'b1, 6'h3F, 1'b0);
    step("fill.full", 1'b0, '0, 1'b0);
    check("fill.wfull", {31'd0, wfull}, 32'd1);
    for (int i = 0; i < DEPTH; i++) step("fill.rd", 1'b0, '0, 1'b1);
    step("fill.empty", 1'b0, '0, 1'b0);
    check("fill.rempty", {31'd0, rempty}, 32'd1);

    // Wrap-around: three fill/drain rounds with incrementing data
    v = 6'h10;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < DEPTH; i++) begin
        step("wrap.wr", 1'b1, v, 1'b0);
        v = v + 1'b1;
      end
      for (int i = 0; i < DEPTH; i++) step("wrap.rd", 1'b0, '0, 1'b1);
    end
    step("wrap.end", 1'b0, '0, 1'b0);

    // Simultaneous read/write at occupancy 5
    for (int i = 0; i < 5; i++) step("sim5.pre", 1'b1, DSIZE'(6'h20 + i), 1'b0);
    for (int i = 0; i < 8; i++) step("sim5.rw", 1'b1, DSIZE'(6'h30 + i), 1'b1);
    for (int i = 0; i < 5; i++) step("sim5.drain", 1'b0, '0, 1'b1);
    step("sim5.end", 1'b0, '0, 1'b0);
    check("sim5.empty", {31'd0, rempty}, 32'd1);

    // Both strobes while full: only the read happens
    for (int i = 0; i < DEPTH; i++) step("fullrw.fill", 1'b1, DSIZE'(i + 3), 1'b0);
    step("fullrw.rw", 1'b1, 6'h3E, 1'b1);
    step("fullrw.after", 1'b0, '0, 1'b0);
    check("fullrw.wfull", {31'd0, wfull}, 32'd0);
    for (int i = 0; i < DEPTH - 1; i++) step("fullrw.drain", 1'b0, '0, 1'b1);

    // Both strobes while empty: only the write happens
    step("emptyrw.rw", 1'b1, 6'h15, 1'b1);
    step("emptyrw.after", 1'b0, '0, 1'b0);
    check("emptyrw.data", {26'd0, rdata}, 32'h15);
    step("emptyrw.rd", 1'b0, '0, 1'b1);

    // Over-read: 4 words, rinc held for 20 cycles
    for (int i = 0; i < 4; i++) step("ovr.wr", 1'b1, DSIZE'(6'h2A + i), 1'b0);
    for (int i = 0; i < 20; i++) step("ovr.rd", 1'b0, '0, 1'b1);
    step("ovr.end", 1'b0, '0, 1'b0);
    check("ovr.rempty", {31'd0, rempty}, 32'd1);
    // After a fresh write, the head must be that word (rptr did not run ahead)
    step("ovr.wr2", 1'b1, 6'h07, 1'b0);
    step("ovr.chk", 1'b0, '0, 1'b0);
    check("ovr.head", {26'd0, rdata}, 32'h07);

    // Randomised traffic
    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom_range(0, 99) < 55), DSIZE'($urandom), 1'($urandom_range(0, 99) < 45));

    // Asynchronous reset between edges with content present
    for (int i = 0; i < 3; i++) step("arst.wr", 1'b1, DSIZE'(i + 9), 1'b0);
    @(negedge wclk);
    winc = 1'b0;
    rinc = 1'b0;
    #2;
    wrst_n = 1'b0;
    #1;
    check("arst.rempty", {31'd0, rempty}, 32'd1);
    check("arst.wfull",  {31'd0, wfull},  32'd0);
    model_q.delete();
    @(negedge wclk);
    wrst_n = 1'b1;
    step("arst.after", 1'b1, 6'h33, 1'b0);
    step("arst.after2", 1'b0, '0, 1'b0);
    step("arst.end", 1'b0, '0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
